mux_gate_scheduler: RTL

MUX_GATE_SCHEDULER -- requirements
Module: mux_gate_scheduler

---
 rtl/mux_gate_pkg.sv | 47 ++++
 rtl/mux2x1.sv | 18 +
 rtl/mux_gate_scheduler.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/mux_gate_pkg.sv
// Shared types for the bit-serial mux-gate scheduler: opcodes, FSM states,
// default sizing and the per-opcode mux input mapping.
package mux_gate_pkg;

  localparam int unsigned NREQ_DEFAULT = 4;
  localparam int unsigned W_DEFAULT    = 8;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NOT  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_XOR  = 3'd6,
    OP_RSVD = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic i0;
    logic i1;
  } mux_sel_t;

  // Data inputs of the 2:1 cell for one bit; the select is always a[k].
  function automatic mux_sel_t mux_inputs(input op_e op, input logic b);
    mux_sel_t s;
    s = '0;
    case (op)
      OP_AND:  begin s.i0 = 1'b0; s.i1 = b;    end
      OP_OR:   begin s.i0 = b;    s.i1 = 1'b1; end
      OP_NOT:  begin s.i0 = 1'b1; s.i1 = 1'b0; end
      OP_NAND: begin s.i0 = 1'b1; s.i1 = ~b;   end
      OP_NOR:  begin s.i0 = ~b;   s.i1 = 1'b0; end
      OP_XNOR: begin s.i0 = ~b;   s.i1 = b;    end
      OP_XOR:  begin s.i0 = b;    s.i1 = ~b;   end
      default: s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mux2x1.sv
// Gate-level 2:1 multiplexer cell: y = s ? i1 : i0.
module mux2x1 (
  input  logic s,
  input  logic i0,
  input  logic i1,
  output logic y
);

  logic s_n;
  logic t0;
  logic t1;

  not u_inv (s_n, s);
  and u_a0  (t0, s_n, i0);
  and u_a1  (t1, s, i1);
  or  u_or  (y, t0, t1);

endmodule

// File: rtl/mux_gate_scheduler.sv
// Round-robin scheduler sharing one mux2x1 cell among NREQ requesters;
// each granted operation is evaluated bit-serially, LSB first.
module mux_gate_scheduler
  import mux_gate_pkg::*;
#(
  parameter  int unsigned NREQ = NREQ_DEFAULT,
  parameter  int unsigned W    = W_DEFAULT,
  localparam int unsigned IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req,
  input  logic [3*NREQ-1:0]   op,
  input  logic [W*NREQ-1:0]   a,
  input  logic [W*NREQ-1:0]   b,
  output logic [NREQ-1:0]     gnt,
  output logic                busy,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [IW-1:0]       res_id,
  output logic [W-1:0]        res_data,
  output logic                res_err
);

  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

  state_e          state_q;
  state_e          state_d;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   pick;
  logic            found;
  logic [NREQ-1:0] rot;

  logic [2:0]      op_pick;
  logic [W-1:0]    a_pick;
  logic [W-1:0]    b_pick;

  op_e             op_q;
  logic [W-1:0]    a_sh;
  logic [W-1:0]    b_sh;
  logic [W-2:0]    res_sh;
  logic [IW-1:0]   id_q;
  logic [CW-1:0]   cnt;

  mux_sel_t        sel;
  logic            mux_y;
  logic            err_c;
  logic            bit_c;
  logic            last_bit;

  logic [NREQ-1:0] gnt_d;
  logic            busy_d;
  logic            valid_d;

  // First pending requester at or after rr_ptr, found on a rotated copy of req.
  always_comb begin
    int unsigned sum;
    found = 1'b0;
    pick  = '0;
    sum   = 0;
    rot   = NREQ'({req, req} >> rr_ptr);
    for (int unsigned o = 0; o < NREQ; o++) begin
      if (!found && rot[o]) begin
        found = 1'b1;
        sum   = 32'(rr_ptr) + o;
        if (sum >= NREQ) sum = sum - NREQ;
        pick  = IW'(sum);
      end
    end
  end

  always_comb begin
    op_pick = '0;
    a_pick  = '0;
    b_pick  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick == IW'(i)) begin
        op_pick = op[3*i +: 3];
        a_pick  = a[W*i +: W];
        b_pick  = b[W*i +: W];
      end
    end
  end

  // Single shared evaluation cell; a reserved opcode masks its output.
  assign sel = mux_inputs(op_q, b_sh[0]);

  mux2x1 u_cell (
    .s  (a_sh[0]),
    .i0 (sel.i0),
    .i1 (sel.i1),
    .y  (mux_y)
  );

  assign err_c    = (op_q == OP_RSVD);
  assign bit_c    = mux_y & ~err_c;
  assign last_bit = (cnt == CW'(W - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (found)     state_d = ST_EVAL;
      ST_EVAL: if (last_bit)  state_d = ST_DONE;
      ST_DONE: if (res_ready) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    gnt_d   = '0;
    busy_d  = (state_d != ST_IDLE);
    valid_d = (state_d == ST_DONE);
    if (state_q == ST_IDLE && found) gnt_d = NREQ'(1) << pick;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt       <= '0;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      res_id    <= '0;
      res_data  <= '0;
      res_err   <= 1'b0;
      rr_ptr    <= '0;
      op_q      <= OP_AND;
      a_sh      <= '0;
      b_sh      <= '0;
      res_sh    <= '0;
      id_q      <= '0;
      cnt       <= '0;
    end else begin
      gnt       <= gnt_d;
      busy      <= busy_d;
      res_valid <= valid_d;
      case (state_q)
        ST_IDLE: begin
          if (found) begin
            op_q   <= op_e'(op_pick);
            a_sh   <= a_pick;
            b_sh   <= b_pick;
            id_q   <= pick;
            cnt    <= '0;
            rr_ptr <= (pick == IW'(NREQ - 1)) ? '0 : pick + IW'(1);
          end
        end
        ST_EVAL: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= (W-1)'({bit_c, res_sh} >> 1);
          cnt    <= cnt + CW'(1);
          if (last_bit) begin
            res_data <= {bit_c, res_sh};
            res_err  <= err_c;
            res_id   <= id_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
